match_req_dispatch: RTL and testbench

- Sits between the job PE and the M match PEs, directly upstream of the match response synchroniser.
- Accepts one lazy-match request group of up to LAZY_LEN lanes from the job PE and issues a fire/strobe pulse that arms the synchroniser.
- Spreads the strobed lanes over NUM_MATCH_REQ_CH request channels, each tagged with its lane index.
- Holds off the next group until the synchroniser reports that the current group's response has been consumed.

---
 rtl/match_req_dispatch.sv | 142 ++++++++++++++
 tb/tb_match_req_dispatch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_req_dispatch.sv
// Lazy-match request dispatcher: accepts one lane group, fires the response synchroniser and spreads the lanes over C channels.
// Optional counters perf_group_cnt/perf_stall_cnt are built when MATCH_REQ_DISPATCH_PERF_EN is defined.
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 2
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module match_req_dispatch #(
   parameter int JOB_PE_IDX = 0,
   parameter int L          = `LAZY_LEN,
   parameter int C          = `NUM_MATCH_REQ_CH,
   parameter int TAG_BITS   = `LAZY_LEN_LOG2,
   parameter int AW         = `ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_group_valid,
   output logic                  req_group_ready,
   input  logic [L-1:0]          req_group_strb,
   input  logic [L*AW-1:0]       req_group_addr,
   output logic                  req_group_fire,
   output logic [L-1:0]          req_group_strb_o,
   input  logic                  resp_group_done,
   output logic [C-1:0]          req_valid,
   input  logic [C-1:0]          req_ready,
   output logic [C*TAG_BITS-1:0] req_tag,
   output logic [C*AW-1:0]       req_addr
`ifdef MATCH_REQ_DISPATCH_PERF_EN
   ,
   output logic [31:0]           perf_group_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   if (L > (1 << TAG_BITS) || JOB_PE_IDX < 0) begin : g_param_check
      $error("match_req_dispatch: lane count exceeds tag range or bad job PE index");
   end

   typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_RESP} state_t;

   state_t               state_q, state_d;
   logic [L-1:0]         pending_q, pending_d, cand;
   logic [L*AW-1:0]      addr_q, src_addr;
   logic [C-1:0]         free, sel_vld;
   logic [TAG_BITS-1:0]  sel_tag  [C];
   logic [AW-1:0]        sel_addr [C];
   logic                 accept;

   // A new group also waits for every channel to drain, so the sync never re-arms mid-group.
   assign req_group_ready  = (state_q == IDLE) && !(|req_valid);
   assign accept           = req_group_valid && req_group_ready;
   assign req_group_fire   = accept;
   assign req_group_strb_o = req_group_strb;
   assign free             = ~req_valid | req_ready;

   // Lane assignment: ascending free channels take the lowest remaining candidate lanes.
   always_comb begin
      cand     = '0;
      src_addr = addr_q;
      if (accept) begin
         cand     = req_group_strb;
         src_addr = req_group_addr;
      end else if (state_q == DISPATCH) begin
         cand = pending_q;
      end
      pending_d = cand;
      for (int j = 0; j < C; j++) begin
         sel_vld[j]  = 1'b0;
         sel_tag[j]  = '0;
         sel_addr[j] = '0;
         if (free[j]) begin
            for (int i = 0; i < L; i++) begin
               if (!sel_vld[j] && pending_d[i]) begin
                  sel_vld[j]   = 1'b1;
                  sel_tag[j]   = TAG_BITS'(i);
                  sel_addr[j]  = src_addr[i*AW +: AW];
                  pending_d[i] = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = (req_group_strb != '0) ? DISPATCH : WAIT_RESP;
         DISPATCH:  if (pending_d == '0) state_d = WAIT_RESP;
         WAIT_RESP: if (resp_group_done) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         addr_q    <= '0;
         req_valid <= '0;
         req_tag   <= '0;
         req_addr  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (accept) addr_q <= req_group_addr;
         // A stalled channel is not free, so its payload is never touched here.
         for (int j = 0; j < C; j++) begin
            if (free[j]) begin
               req_valid[j] <= sel_vld[j];
               if (sel_vld[j]) begin
                  req_tag[j*TAG_BITS +: TAG_BITS] <= sel_tag[j];
                  req_addr[j*AW +: AW]            <= sel_addr[j];
               end
            end
         end
      end
   end

`ifdef MATCH_REQ_DISPATCH_PERF_EN
   logic stall;
   assign stall = |(req_valid & ~req_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_group_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (accept && perf_group_cnt != '1) perf_group_cnt <= perf_group_cnt + 32'd1;
         if (stall && perf_stall_cnt != '1)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_match_req_dispatch.sv
// Scoreboard bench for match_req_dispatch: accepted lanes are queued as expected requests and a
// negedge monitor retires them on channel handshakes, alongside directed scenario checks.
module tb_match_req_dispatch;
   localparam int L  = 4;
   localparam int C  = 2;
   localparam int TB = 2;
   localparam int AW = 16;

   logic            clk;
   logic            rst_n;
   logic            req_group_valid;
   logic            req_group_ready;
   logic [L-1:0]    req_group_strb;
   logic [L*AW-1:0] req_group_addr;
   logic            req_group_fire;
   logic [L-1:0]    req_group_strb_o;
   logic            resp_group_done;
   logic [C-1:0]    req_valid;
   logic [C-1:0]    req_ready;
   logic [C*TB-1:0] req_tag;
   logic [C*AW-1:0] req_addr;
`ifdef MATCH_REQ_DISPATCH_PERF_EN
   logic [31:0]     perf_group_cnt;
   logic [31:0]     perf_stall_cnt;
   int              grp_m;
   int              stall_m;
`endif

   match_req_dispatch #(.JOB_PE_IDX(0), .L(L), .C(C), .TAG_BITS(TB), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_group_valid(req_group_valid), .req_group_ready(req_group_ready),
      .req_group_strb(req_group_strb), .req_group_addr(req_group_addr),
      .req_group_fire(req_group_fire), .req_group_strb_o(req_group_strb_o),
      .resp_group_done(resp_group_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_addr(req_addr)
`ifdef MATCH_REQ_DISPATCH_PERF_EN
      , .perf_group_cnt(perf_group_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   typedef struct {
      logic [TB-1:0] tag;
      logic [AW-1:0] addr;
   } lane_t;

   lane_t        exp_q[$];
   bit           busy;
   bit           rdy_rand;
   int           checks;
   int           errors;
   logic [C-1:0] hold;
   logic [TB-1:0] ptag  [C];
   logic [AW-1:0] paddr [C];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_ch(input int j, input logic [TB-1:0] t, input logic [AW-1:0] a);
      chk($sformatf("ch%0d_valid", j), 64'(req_valid[j]), 64'd1);
      chk($sformatf("ch%0d_tag", j), 64'(req_tag[j*TB +: TB]), 64'(t));
      chk($sformatf("ch%0d_addr", j), 64'(req_addr[j*AW +: AW]), 64'(a));
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_rand) req_ready = C'($urandom);
   end

   // Monitor: group handshake model, channel scoreboard and hold-stability checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         busy = 1'b0;
         hold = '0;
`ifdef MATCH_REQ_DISPATCH_PERF_EN
         grp_m   = 0;
         stall_m = 0;
`endif
      end else begin
         chk("group_ready", 64'(req_group_ready), 64'(!busy));
         chk("fire", 64'(req_group_fire), 64'(req_group_valid && !busy));
         if (req_group_valid && !busy) chk("strb_o", 64'(req_group_strb_o), 64'(req_group_strb));
         if (exp_q.size() == 0) chk("no_spurious_valid", 64'(req_valid), 64'd0);
         for (int j = 0; j < C; j++) begin
            if (hold[j]) begin
               chk("hold_valid", 64'(req_valid[j]), 64'd1);
               chk("hold_tag", 64'(req_tag[j*TB +: TB]), 64'(ptag[j]));
               chk("hold_addr", 64'(req_addr[j*AW +: AW]), 64'(paddr[j]));
            end
         end
         for (int j = 0; j < C; j++) begin
            if (req_valid[j] && req_ready[j]) begin
               int k;
               k = -1;
               foreach (exp_q[n]) if (k < 0 && exp_q[n].tag == req_tag[j*TB +: TB]) k = n;
               chk("hs_lane_expected", 64'(k >= 0), 64'd1);
               if (k >= 0) begin
                  chk("hs_addr", 64'(req_addr[j*AW +: AW]), 64'(exp_q[k].addr));
                  exp_q.delete(k);
               end
            end
         end
`ifdef MATCH_REQ_DISPATCH_PERF_EN
         chk("perf_group", 64'(perf_group_cnt), 64'(grp_m));
         chk("perf_stall", 64'(perf_stall_cnt), 64'(stall_m));
         if (|(req_valid & ~req_ready)) stall_m++;
`endif
         for (int j = 0; j < C; j++) begin
            hold[j]  = req_valid[j] && !req_ready[j];
            ptag[j]  = req_tag[j*TB +: TB];
            paddr[j] = req_addr[j*AW +: AW];
         end
         if (req_group_valid && !busy) begin
            for (int i = 0; i < L; i++) begin
               if (req_group_strb[i]) begin
                  lane_t e;
                  e.tag  = TB'(i);
                  e.addr = req_group_addr[i*AW +: AW];
                  exp_q.push_back(e);
               end
            end
            busy = 1'b1;
`ifdef MATCH_REQ_DISPATCH_PERF_EN
            grp_m++;
`endif
         end else if (resp_group_done && busy && exp_q.size() == 0) begin
            busy = 1'b0;
         end
      end
   end

   task automatic send_group(input logic [L-1:0] s, input logic [L*AW-1:0] a);
      int n;
      n = 0;
      req_group_strb  = s;
      req_group_addr  = a;
      req_group_valid = 1'b1;
      @(negedge clk);
      while (!req_group_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("accept_timeout", 64'(req_group_ready), 64'd1);
      @(posedge clk);
      #1 req_group_valid = 1'b0;
   endtask

   task automatic drain_and_done();
      int n;
      n = 0;
      @(negedge clk);
      while (exp_q.size() != 0 && n < 500) begin
         n++;
         @(negedge clk);
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1 resp_group_done = 1'b1;
      @(posedge clk);
      #1 resp_group_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_group_valid = 1'b0; req_group_strb = '0; req_group_addr = '0;
      resp_group_done = 1'b0; req_ready = '0; rdy_rand = 1'b0;
      checks = 0; errors = 0; busy = 1'b0; hold = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(req_group_ready), 64'd1);
      chk("rst_valid", 64'(req_valid), 64'd0);
      chk("rst_tag", 64'(req_tag), 64'd0);
      chk("rst_addr", 64'(req_addr), 64'd0);
      rst_n = 1'b1;

      // basic issue, no back-pressure
      req_ready = 2'b11;
      send_group(4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
      @(negedge clk); chk_ch(0, 2'd0, 16'h0010); chk_ch(1, 2'd1, 16'h0020);
      @(negedge clk); chk_ch(0, 2'd2, 16'h0030); chk_ch(1, 2'd3, 16'h0040);
      @(negedge clk);
      chk("basic_wait_ready", 64'(req_group_ready), 64'd0);
      chk("basic_wait_valid", 64'(req_valid), 64'd0);
      drain_and_done();

      // sparse strobe
      send_group(4'b1010, {16'h0d04, 16'h0c03, 16'h0b02, 16'h0a01});
      @(negedge clk); chk_ch(0, 2'd1, 16'h0b02); chk_ch(1, 2'd3, 16'h0d04);
      drain_and_done();

      // back-pressure on ch0 plus a stray done while dispatching
      req_ready = 2'b10;
      send_group(4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
      resp_group_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic [AW-1:0] a1;
         a1 = AW'((k + 2) * 16);
         @(negedge clk);
         chk_ch(0, 2'd0, 16'h0010);
         chk_ch(1, TB'(k + 1), a1);
         chk("bp_ready", 64'(req_group_ready), 64'd0);
         @(posedge clk);
         #1 resp_group_done = 1'b0;
      end
      req_ready = 2'b11;
      @(negedge clk); chk("bp_release_valid", 64'(req_valid), 64'b01);
      drain_and_done();

      // empty group
      send_group(4'b0000, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
      @(negedge clk);
      chk("empty_valid", 64'(req_valid), 64'd0);
      chk("empty_ready", 64'(req_group_ready), 64'd0);
      drain_and_done();
      @(negedge clk); chk("empty_ready_after_done", 64'(req_group_ready), 64'd1);

      // next group offered during WAIT_RESP
      @(posedge clk); #1;
      send_group(4'b0001, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      req_group_strb  = 4'b0110;
      req_group_addr  = {16'h0b04, 16'h0b03, 16'h0b02, 16'h0b01};
      req_group_valid = 1'b1;
      repeat (3) begin
         @(negedge clk); chk("order_held_off", 64'(req_group_ready), 64'd0);
      end
      @(posedge clk); #1 resp_group_done = 1'b1;
      @(posedge clk); #1 resp_group_done = 1'b0;
      @(negedge clk); chk("order_accept", 64'(req_group_fire), 64'd1);
      @(posedge clk); #1 req_group_valid = 1'b0;
      @(negedge clk); chk_ch(0, 2'd1, 16'h0b02); chk_ch(1, 2'd2, 16'h0b03);
      drain_and_done();

      // asynchronous reset in the middle of DISPATCH
      req_ready = 2'b00;
      send_group(4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(req_valid), 64'd0);
      chk("async_rst_ready", 64'(req_group_ready), 64'd1);
`ifdef MATCH_REQ_DISPATCH_PERF_EN
      chk("async_rst_perf_group", 64'(perf_group_cnt), 64'd0);
      chk("async_rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      req_ready = 2'b11;

      // randomized groups under random back-pressure
      rdy_rand = 1'b1;
      for (int g = 0; g < 60; g++) begin
         send_group(L'($urandom), {$urandom, $urandom});
         drain_and_done();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rdy_rand = 1'b0;
      req_ready = 2'b11;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
